// File: rtl/conv3x3_engine_pkg.sv
// conv_pkg: shared sizes, state encoding and small helpers for conv3x3_engine.
//   K_W/IMG_W         kernel and image edge lengths
//   N_KER/N_IMG/N_IN  word counts of the operand stream
//   N_OUT             number of results per frame
//   ACC_W             accumulator width (9 products of 32 bits cannot overflow it)
//   sat16             clamp an accumulator value to signed 16 bits
//   tap_offset        image address offset (row*IMG_W + col) of kernel tap t
package conv_pkg;

  localparam int DATA_W = 16;
  localparam int K_W    = 3;
  localparam int IMG_W  = 4;
  localparam int N_KER  = 9;
  localparam int N_IMG  = 16;
  localparam int N_IN   = 25;
  localparam int N_OUT  = 4;
  localparam int ACC_W  = 36;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    logic signed [DATA_W-1:0] r;
    if (v > 36'sd32767) begin
      r = 16'sh7fff;
    end else if (v < -36'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

  // Tap t covers kernel (t/3, t%3); in the row-major image that lands
  // (t/3)*IMG_W + t%3 words past the top-left corner of the output window.
  function automatic logic [4:0] tap_offset(input logic [3:0] tap);
    logic [4:0] r;
    case (tap)
      4'd0:    r = 5'd0;
      4'd1:    r = 5'd1;
      4'd2:    r = 5'd2;
      4'd3:    r = 5'd4;
      4'd4:    r = 5'd5;
      4'd5:    r = 5'd6;
      4'd6:    r = 5'd8;
      4'd7:    r = 5'd9;
      4'd8:    r = 5'd10;
      default: r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/conv3x3_engine_if.sv
// conv3x3_engine_if: input word stream plus result stream of the engine.
//   in_valid/in_ready/in_data            operand words into the engine
//   out_valid/out_ready/out_data/out_last results out of the engine
//   master: the front end (source of operands, sink of results)
//   slave:  the engine
interface conv3x3_engine_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv3x3_engine_mac.sv
// conv_mac: signed 16x16 multiplier feeding a 36-bit accumulator.
//   CLKOUT, rst_n  clock and async active-low reset
//   clr            synchronous clear of the accumulator
//   en             accumulate this cycle
//   first          first tap: load the product instead of adding to it
//   a, b           signed operands
//   acc            accumulator value
module conv_mac
  import conv_pkg::*;
(
  input  logic                    CLKOUT,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    first,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_q, acc_d;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = first ? prod_ext : acc_q + prod_ext;
    end
  end

  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv3x3_engine.sv
// conv3x3_engine: 3x3 "valid" correlation of a 4x4 image, one MAC per cycle.
//   CLKOUT, rst_n  clock and async active-low reset
//   clr            synchronous abort back to LOAD
//   s              operand input stream and result output stream (slave side)
//   busy           high while computing or presenting results
//   SHIFT          arithmetic right shift applied before saturation
//
// state   | meaning
// --------+------------------------------------------------------------
// LOAD    | accepting 25 words: 9 kernel then 16 image, row-major
// COMPUTE | 4 results x (9 tap cycles + 1 writeback cycle)
// OUTPUT  | presenting res[0..3], advancing on out_ready
module conv3x3_engine
  import conv_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic             CLKOUT,
  input  logic             rst_n,
  input  logic             clr,
  conv3x3_engine_if.slave  s,
  output logic             busy
);

  state_t      state_q, state_d;
  logic [4:0]  wcnt_q, wcnt_d;
  logic [3:0]  tap_q, tap_d;
  logic [1:0]  oidx_q, oidx_d;
  logic [1:0]  ocnt_q, ocnt_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;

  logic [DATA_W-1:0] op_q  [N_IN];
  logic [DATA_W-1:0] op_d  [N_IN];
  logic [DATA_W-1:0] res_q [N_OUT];
  logic [DATA_W-1:0] res_d [N_OUT];

  logic        accept;
  logic        take;
  logic        writeback;
  logic        mac_en;
  logic [4:0]  win_base;
  logic [4:0]  img_idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sh;

  assign accept    = (state_q == LOAD) && s.in_valid && in_ready_q;
  assign take      = (state_q == OUTPUT) && out_valid_q && s.out_ready;
  assign writeback = (state_q == COMPUTE) && (tap_q == 4'd9);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      wcnt_q      <= '0;
      tap_q       <= '0;
      oidx_q      <= '0;
      ocnt_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      tap_q       <= tap_d;
      oidx_q      <= oidx_d;
      ocnt_q      <= ocnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tap_d   = tap_q;
    oidx_d  = oidx_q;
    ocnt_d  = ocnt_q;
    if (clr) begin
      state_d = LOAD;
      wcnt_d  = '0;
      tap_d   = '0;
      oidx_d  = '0;
      ocnt_d  = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (wcnt_q == 5'(N_IN - 1)) begin
              wcnt_d  = '0;
              tap_d   = '0;
              oidx_d  = '0;
              state_d = COMPUTE;
            end else begin
              wcnt_d = wcnt_q + 5'd1;
            end
          end
        end
        COMPUTE: begin
          if (tap_q == 4'd9) begin
            tap_d  = '0;
            oidx_d = oidx_q + 2'd1;
            if (oidx_q == 2'(N_OUT - 1)) begin
              ocnt_d  = '0;
              state_d = OUTPUT;
            end
          end else begin
            tap_d = tap_q + 4'd1;
          end
        end
        OUTPUT: begin
          if (take) begin
            ocnt_d = ocnt_q + 2'd1;
            if (ocnt_q == 2'(N_OUT - 1)) begin
              state_d = LOAD;
            end
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  // Handshake outputs are registered copies of where the FSM is headed.
  always_comb begin
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == OUTPUT);
    busy_d      = (state_d != LOAD);
  end

  // ------------------------------------------------------------ datapath
  // Output window (o>>1, o&1) starts at image word o[1]*IMG_W + o[0].
  assign win_base = {2'b00, oidx_q[1], 1'b0, oidx_q[0]};
  assign img_idx  = 5'(N_KER) + win_base + tap_offset(tap_q);
  assign mac_en   = (state_q == COMPUTE) && (tap_q != 4'd9);
  assign acc_sh   = acc >>> SHIFT;

  conv_mac u_mac (
    .CLKOUT (CLKOUT),
    .rst_n  (rst_n),
    .clr    (clr),
    .en     (mac_en),
    .first  (tap_q == 4'd0),
    .a      ($signed(op_q[{1'b0, tap_q}])),
    .b      ($signed(op_q[img_idx])),
    .acc    (acc)
  );

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      op_d[i] = op_q[i];
    end
    if (!clr && accept) begin
      op_d[wcnt_q] = s.in_data;
    end
  end

  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      res_d[i] = res_q[i];
    end
    if (!clr && writeback) begin
      res_d[oidx_q] = sat16(acc_sh);
    end
  end

  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        op_q[i] <= '0;
      end
      for (int i = 0; i < N_OUT; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        op_q[i] <= op_d[i];
      end
      for (int i = 0; i < N_OUT; i++) begin
        res_q[i] <= res_d[i];
      end
    end
  end

  assign s.in_ready  = in_ready_q;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = res_q[ocnt_q];
  assign s.out_last  = out_valid_q && (ocnt_q == 2'(N_OUT - 1));
  assign busy        = busy_q;

endmodule

// File: tb/tb_conv3x3_engine.sv
module tb_conv3x3_engine;

  logic        CLKOUT;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        busy0, busy1;

  conv3x3_engine_if i0 ();
  conv3x3_engine_if i1 ();

  // Both instances see identical stimulus; i1 runs with SHIFT=2.
  assign i0.in_valid  = in_valid;
  assign i0.in_data   = in_data;
  assign i0.out_ready = out_ready;
  assign i1.in_valid  = in_valid;
  assign i1.in_data   = in_data;
  assign i1.out_ready = out_ready;

  conv3x3_engine #(.SHIFT(0)) dut0 (.CLKOUT(CLKOUT), .rst_n(rst_n), .clr(clr), .s(i0.slave), .busy(busy0));
  conv3x3_engine #(.SHIFT(2)) dut1 (.CLKOUT(CLKOUT), .rst_n(rst_n), .clr(clr), .s(i1.slave), .busy(busy1));

  initial begin
    CLKOUT = 1'b0;
    forever #5 CLKOUT = ~CLKOUT;
  end

  int cyc = 0;
  always @(posedge CLKOUT) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [15:0] kern [9];
  logic [15:0] img  [16];

  // Reference: direct 2-D correlation, shift, clamp.
  function automatic int model(input int o, input int sh);
    longint acc;
    acc = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        acc += longint'($signed(kern[r*3+c])) *
               longint'($signed(img[(o/2 + r)*4 + (o%2) + c]));
    acc = acc >>> sh;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  int q0[$];
  int q1[$];
  int idx0 = 0, idx1 = 0;
  int got0 [4];
  int got1 [4];

  // Scoreboard: every cycle a result is shown it must equal the queue head.
  always @(negedge CLKOUT) begin
    if (rst_n) begin
      if (i0.out_valid) begin
        check("dut0_has_expected", int'(q0.size() > 0), 1);
        if (q0.size() > 0) begin
          check("dut0_out_data", int'($signed(i0.out_data)), q0[0]);
          check("dut0_out_last", int'(i0.out_last), int'(idx0 == 3));
          if (out_ready) begin
            got0[idx0] = int'($signed(i0.out_data));
            void'(q0.pop_front());
            idx0 = (idx0 + 1) % 4;
          end
        end
      end
      if (i1.out_valid) begin
        check("dut1_has_expected", int'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          check("dut1_out_data", int'($signed(i1.out_data)), q1[0]);
          check("dut1_out_last", int'(i1.out_last), int'(idx1 == 3));
          if (out_ready) begin
            got1[idx1] = int'($signed(i1.out_data));
            void'(q1.pop_front());
            idx1 = (idx1 + 1) % 4;
          end
        end
      end
    end
  end

  task automatic set_frame(input logic [15:0] kv, input int mode, input logic [15:0] iv);
    for (int i = 0; i < 9; i++) kern[i] = kv;
    for (int i = 0; i < 16; i++) img[i] = (mode == 1) ? 16'(i + 1) : iv;
  endtask

  task automatic flush();
    q0.delete();
    q1.delete();
    idx0 = 0;
    idx1 = 0;
  endtask

  // Leaves the bench at #1 after the edge that accepted word 24.
  task automatic send_frame(input bit gap);
    int  n, g;
    bit  acc;
    n = 0;
    g = 0;
    while (n < 25 && g < 500) begin
      if (gap && (g % 2 == 1)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = (n < 9) ? kern[n] : img[n-9];
      end
      acc = in_valid && i0.in_ready;
      @(posedge CLKOUT);
      #1;
      g++;
      if (acc) n++;
    end
    in_valid = 1'b0;
    check("frame_accepted_words", n, 25);
    for (int o = 0; o < 4; o++) begin
      q0.push_back(model(o, 0));
      q1.push_back(model(o, 2));
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((q0.size() != 0 || q1.size() != 0) && g < 300) begin
      @(posedge CLKOUT);
      #1;
      g++;
    end
    check("drain_remaining", q0.size() + q1.size(), 0);
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    while (!i0.out_valid && g < 100) begin
      @(posedge CLKOUT);
      #1;
      g++;
    end
    check("wait_out_valid", int'(i0.out_valid), 1);
  endtask

  task automatic check_got0(input string name, input int a, input int b, input int c, input int d);
    check({name, "_r0"}, got0[0], a);
    check({name, "_r1"}, got0[1], b);
    check({name, "_r2"}, got0[2], c);
    check({name, "_r3"}, got0[3], d);
  endtask

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge CLKOUT);
    #1;
    check("rst_in_ready",  int'(i0.in_ready), 0);
    check("rst_out_valid", int'(i0.out_valid), 0);
    check("rst_out_last",  int'(i0.out_last), 0);
    check("rst_out_data",  int'(i0.out_data), 0);
    check("rst_busy",      int'(busy0), 0);
    @(negedge CLKOUT);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", int'(i0.in_ready), 0);
    @(posedge CLKOUT);
    #1;
    check("in_ready_after_edge", int'(i0.in_ready), 1);

    // all-ones kernel, image 1..16, with latency and drain timing
    set_frame(16'd1, 1, 16'd0);
    send_frame(1'b0);
    check("compute_in_ready", int'(i0.in_ready), 0);
    check("compute_busy", int'(busy0), 1);
    repeat (39) @(posedge CLKOUT);
    #1;
    check("out_valid_at_e0_39", int'(i0.out_valid), 0);
    @(posedge CLKOUT);
    #1;
    check("out_valid_at_e0_40", int'(i0.out_valid), 1);
    repeat (3) @(posedge CLKOUT);
    #1;
    check("in_ready_before_last_take", int'(i0.in_ready), 0);
    @(posedge CLKOUT);
    #1;
    check("in_ready_after_last_take", int'(i0.in_ready), 1);
    check("out_valid_after_last_take", int'(i0.out_valid), 0);
    wait_drain();
    check_got0("ones", 54, 63, 90, 99);
    check("ones_shift2_r0", got1[0], 13);
    check("ones_shift2_r3", got1[3], 24);

    // identity kernel
    set_frame(16'd0, 1, 16'd0);
    kern[4] = 16'd1;
    send_frame(1'b0);
    wait_drain();
    check_got0("identity", 6, 7, 10, 11);

    // saturation high / low, and SHIFT=2 scaling
    set_frame(16'h7fff, 0, 16'h7fff);
    send_frame(1'b0);
    wait_drain();
    check_got0("sat_pos", 32767, 32767, 32767, 32767);
    set_frame(16'h8000, 0, 16'h7fff);
    send_frame(1'b0);
    wait_drain();
    check_got0("sat_neg", -32768, -32768, -32768, -32768);
    set_frame(16'd1, 0, 16'd4);
    send_frame(1'b0);
    wait_drain();
    check("fours_shift0", got0[2], 36);
    check("fours_shift2_r0", got1[0], 9);
    check("fours_shift2_r3", got1[3], 9);

    // backpressure during result 1
    set_frame(16'd1, 1, 16'd0);
    out_ready = 1'b0;
    send_frame(1'b0);
    wait_valid();
    out_ready = 1'b1;
    @(posedge CLKOUT);
    #1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLKOUT);
      #1;
      check("bp_hold_data", int'($signed(i0.out_data)), 63);
      check("bp_in_ready", int'(i0.in_ready), 0);
    end
    out_ready = 1'b1;
    wait_drain();
    check_got0("bp", 54, 63, 90, 99);

    // gapped input, then in_valid held high across COMPUTE
    send_frame(1'b1);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int k = 0; k < 40; k++) begin
      check("gap_in_ready_low", int'(i0.in_ready), 0);
      @(posedge CLKOUT);
      #1;
    end
    in_valid = 1'b0;
    wait_drain();
    check_got0("gapped", 54, 63, 90, 99);

    // clr mid-COMPUTE
    send_frame(1'b0);
    repeat (15) @(posedge CLKOUT);
    #1;
    clr = 1'b1;
    @(posedge CLKOUT);
    #1;
    clr = 1'b0;
    check("clr_out_valid", int'(i0.out_valid), 0);
    check("clr_busy", int'(busy0), 0);
    check("clr_in_ready", int'(i0.in_ready), 1);
    flush();
    set_frame(16'd0, 1, 16'd0);
    kern[4] = 16'd1;
    send_frame(1'b0);
    wait_drain();
    check_got0("after_clr", 6, 7, 10, 11);

    // reset mid-OUTPUT
    set_frame(16'd1, 1, 16'd0);
    out_ready = 1'b0;
    send_frame(1'b0);
    wait_valid();
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(i0.out_valid), 0);
    check("arst_busy", int'(busy0), 0);
    flush();
    @(negedge CLKOUT);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_frame(1'b0);
    wait_drain();
    check_got0("after_rst", 54, 63, 90, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
